// File: rtl/alu_req_initiator_if.sv
// Bundle between the ALU request initiator and its environment.
// Ports: command stream in, ALU request/valid, response stream out, status.
interface alu_req_initiator_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_op;
  logic             cmd_last;

  logic             alu_request;
  logic [WIDTH-1:0] alu_operandA;
  logic [WIDTH-1:0] alu_operandB;
  logic [1:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;
  logic             alu_valid;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_timeout;
  logic             rsp_last;

  logic             done;
  logic [15:0]      txn_count;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_last,
    output cmd_ready,
    output alu_request, alu_operandA, alu_operandB, alu_opcode,
    input  alu_result, alu_valid,
    output rsp_valid, rsp_result, rsp_timeout, rsp_last,
    input  rsp_ready,
    output done, txn_count
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_last,
    input  cmd_ready,
    input  alu_request, alu_operandA, alu_operandB, alu_opcode,
    output alu_result, alu_valid,
    input  rsp_valid, rsp_result, rsp_timeout, rsp_last,
    output rsp_ready,
    input  done, txn_count
  );
endinterface

// File: rtl/alu_req_initiator.sv
// ALU request initiator: buffers commands, issues one ALU request at a
// time with timeout, returns results in order. Ports: clk, reset, bus.
module alu_req_initiator #(
  parameter int WIDTH     = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic               clk,
  input  logic               reset,
  alu_req_initiator_if.master bus
);
  localparam int AW = $clog2(CMD_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             last;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE, ISSUE, RESP, DONE
  } state_t;

  cmd_t             mem_q [CMD_DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  state_t           state_q;
  logic [15:0]      tmr_q;
  logic             cmd_ready_q;
  logic             req_q;
  logic [WIDTH-1:0] opa_q, opb_q;
  logic [1:0]       opc_q;
  logic             last_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_timeout_q;
  logic             rsp_last_q;
  logic             done_q;
  logic [15:0]      txn_q;
  logic             push, pop;
  cmd_t             head;

  assign push  = bus.cmd_valid && cmd_ready_q;
  assign pop   = (state_q == IDLE) && (cnt_q != '0);
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);
  assign head  = mem_q[rd_q];

  // Storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= '{a: bus.cmd_a, b: bus.cmd_b,
                       op: bus.cmd_op, last: bus.cmd_last};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q          <= '0;
      rd_q          <= '0;
      cnt_q         <= '0;
      state_q       <= IDLE;
      tmr_q         <= '0;
      cmd_ready_q   <= 1'b1;
      req_q         <= 1'b0;
      opa_q         <= '0;
      opb_q         <= '0;
      opc_q         <= '0;
      last_q        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_last_q    <= 1'b0;
      done_q        <= 1'b0;
      txn_q         <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      // Registered from next occupancy, so a pop only frees a slot
      // on the following cycle.
      cmd_ready_q <= (cnt_d != CW'(CMD_DEPTH));
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            opa_q   <= head.a;
            opb_q   <= head.b;
            opc_q   <= head.op;
            last_q  <= head.last;
            req_q   <= 1'b1;
            tmr_q   <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          tmr_q <= tmr_q + 16'd1;
          // alu_valid takes priority over a coinciding timeout.
          if (bus.alu_valid) begin
            rsp_result_q  <= bus.alu_result;
            rsp_timeout_q <= 1'b0;
            rsp_last_q    <= last_q;
            rsp_valid_q   <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= RESP;
          end else if (tmr_q == 16'(TIMEOUT - 1)) begin
            rsp_result_q  <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_last_q    <= last_q;
            rsp_valid_q   <= 1'b1;
            req_q         <= 1'b0;
            state_q       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (txn_q != 16'hFFFF) txn_q <= txn_q + 16'd1;
            if (rsp_last_q) begin
              done_q      <= 1'b1;
              cmd_ready_q <= 1'b0;
              state_q     <= DONE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DONE: begin
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.alu_request  = req_q;
  assign bus.alu_operandA = opa_q;
  assign bus.alu_operandB = opb_q;
  assign bus.alu_opcode   = opc_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_timeout  = rsp_timeout_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.done         = done_q;
  assign bus.txn_count    = txn_q;
endmodule

// File: tb/tb_alu_req_initiator.sv
// Directed bench for alu_req_initiator.
// Drives commands, plays the ALU and the response consumer.
module tb_alu_req_initiator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_req_initiator_if #(.WIDTH(32)) bus ();

  alu_req_initiator #(
    .WIDTH(32), .CMD_DEPTH(4), .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push1(logic [31:0] a, logic [31:0] b, logic last);
    bus.cmd_valid = 1'b1;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_last = last;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_req(string tag);
    int n = 0;
    while (!bus.alu_request && n < 8) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.alu_request), 1);
  endtask

  initial begin
    int acc;
    int n;
    logic hs;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.cmd_last = 1'b0;
    bus.alu_result = '0;
    bus.alu_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    tick();
    do_reset();
    chk("rst_req", 32'(bus.alu_request), 0);
    chk("rst_rspv", 32'(bus.rsp_valid), 0);
    chk("rst_ready", 32'(bus.cmd_ready), 1);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_txn", 32'(bus.txn_count), 0);

    // Single add 5+7, ALU answers on 3rd request edge
    push1(5, 7, 1'b1);
    chk("add_req_lat", 32'(bus.alu_request), 0);
    tick();
    chk("add_req1", 32'(bus.alu_request), 1);
    chk("add_opa", bus.alu_operandA, 5);
    chk("add_opb", bus.alu_operandB, 7);
    tick();
    chk("add_req2", 32'(bus.alu_request), 1);
    tick();
    chk("add_req3", 32'(bus.alu_request), 1);
    chk("add_opa_stable", bus.alu_operandA, 5);
    bus.alu_valid = 1'b1;
    bus.alu_result = 12;
    tick();
    bus.alu_valid = 1'b0;
    chk("add_req_off", 32'(bus.alu_request), 0);
    chk("add_rspv", 32'(bus.rsp_valid), 1);
    chk("add_res", bus.rsp_result, 12);
    chk("add_tmo", 32'(bus.rsp_timeout), 0);
    chk("add_last", 32'(bus.rsp_last), 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("add_rspv_clr", 32'(bus.rsp_valid), 0);
    chk("add_done", 32'(bus.done), 1);
    chk("add_txn", 32'(bus.txn_count), 1);
    chk("add_ready", 32'(bus.cmd_ready), 0);

    // FIFO fill with silent ALU
    do_reset();
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a = 32'(acc + 1);
      bus.cmd_b = 32'(100 + acc);
      bus.cmd_last = 1'b0;
      hs = bus.cmd_ready;
      tick();
      if (hs) acc++;
    end
    bus.cmd_valid = 1'b0;
    chk("fill_accepted", 32'(acc), 5);
    chk("fill_ready", 32'(bus.cmd_ready), 0);
    for (int k = 0; k < 5; k++) begin
      wait_req("fill_req");
      chk("fill_opa", bus.alu_operandA, 32'(k + 1));
      chk("fill_opb", bus.alu_operandB, 32'(100 + k));
      bus.alu_valid = 1'b1;
      bus.alu_result = 32'(k + 1 + 100 + k);
      tick();
      bus.alu_valid = 1'b0;
      chk("fill_rspv", 32'(bus.rsp_valid), 1);
      chk("fill_res", bus.rsp_result, 32'(101 + 2 * k));
      chk("fill_last", 32'(bus.rsp_last), 0);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      if (k == 0) begin
        chk("pop_ready_lo", 32'(bus.cmd_ready), 0);
        chk("pop_req_lo", 32'(bus.alu_request), 0);
        tick();
        chk("pop_ready_hi", 32'(bus.cmd_ready), 1);
        chk("pop_req_hi", 32'(bus.alu_request), 1);
      end
    end
    chk("fill_txn", 32'(bus.txn_count), 5);

    // Timeout, second command queued behind it
    push1(1, 2, 1'b0);
    push1(3, 4, 1'b0);
    n = 0;
    while (bus.alu_request && n < 400) begin
      n++;
      tick();
    end
    chk("tmo_cycles", 32'(n), 255);
    chk("tmo_rspv", 32'(bus.rsp_valid), 1);
    chk("tmo_res", bus.rsp_result, 0);
    chk("tmo_flag", 32'(bus.rsp_timeout), 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("tmo_gap", 32'(bus.alu_request), 0);
    tick();
    chk("tmo_next_req", 32'(bus.alu_request), 1);
    chk("tmo_next_opa", bus.alu_operandA, 3);

    // Valid coincides with the timeout edge
    for (int i = 0; i < 254; i++) tick();
    chk("tie_req", 32'(bus.alu_request), 1);
    bus.alu_valid = 1'b1;
    bus.alu_result = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    chk("tie_rspv", 32'(bus.rsp_valid), 1);
    chk("tie_res", bus.rsp_result, 32'hDEADBEEF);
    chk("tie_tmo", 32'(bus.rsp_timeout), 0);

    // Backpressure with two commands queued
    for (int i = 0; i < 10; i++) begin
      if (i < 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_a = (i == 0) ? 32'd9 : 32'd11;
        bus.cmd_b = (i == 0) ? 32'd9 : 32'd1;
        bus.cmd_last = 1'b0;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      tick();
      chk("bp_rspv", 32'(bus.rsp_valid), 1);
      chk("bp_res", bus.rsp_result, 32'hDEADBEEF);
      chk("bp_req", 32'(bus.alu_request), 0);
      chk("bp_txn", 32'(bus.txn_count), 6);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_txn_hs", 32'(bus.txn_count), 7);
    tick();
    chk("bp_next_req", 32'(bus.alu_request), 1);
    chk("bp_next_opa", bus.alu_operandA, 9);

    // Reset mid-ISSUE with three queued
    push1(20, 1, 1'b0);
    push1(21, 1, 1'b1);
    chk("mid_req", 32'(bus.alu_request), 1);
    do_reset();
    chk("mid_req_clr", 32'(bus.alu_request), 0);
    chk("mid_rspv", 32'(bus.rsp_valid), 0);
    chk("mid_ready", 32'(bus.cmd_ready), 1);
    chk("mid_done", 32'(bus.done), 0);
    chk("mid_txn", 32'(bus.txn_count), 0);
    bus.alu_valid = 1'b1;
    bus.alu_result = 32'h55;
    tick();
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("late_rspv", 32'(bus.rsp_valid), 0);
    chk("late_req", 32'(bus.alu_request), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_req_initiator.md
Name: alu_req_initiator

Overview:
- Synthesizable initiator (requester) for the proto ALU request/valid protocol.
- Replaces the software-driven bench as the command source.
- Accepts commands (operandA, operandB, opcode, last) on an upstream valid/ready stream and buffers them in a small FIFO.
- Issues one ALU transaction at a time, waits for valid or times out, then returns the result on a downstream valid/ready stream.
- Sits between a host/transactor command channel and the proto_alu responder.

Parameters:
- WIDTH, 32, operand/result width.
- CMD_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255, maximum cycles alu_request stays high waiting for alu_valid; range 1..65535.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at an edge.
- cmd_a  in  WIDTH  operandA.
- cmd_b  in  WIDTH  operandB.
- cmd_op  in  2  opcode.
- cmd_last  in  1  final transaction of the run.
- alu_request  out  1  request to ALU.
- alu_operandA  out  WIDTH  operandA to ALU.
- alu_operandB  out  WIDTH  operandB to ALU.
- alu_opcode  out  2  opcode to ALU.
- alu_result  in  WIDTH  ALU result.
- alu_valid  in  1  ALU result valid.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_result  out  WIDTH  captured result; 0 on timeout.
- rsp_timeout  out  1  response produced by timeout.
- rsp_last  out  1  copy of cmd_last for this transaction.
- done  out  1  sticky; set when the last response is consumed.
- txn_count  out  16  responses delivered; saturates at 0xFFFF.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk. Reset is sampled on the rising edge of clk while reset==0.
- Reset values, all outputs registered:
  - 0: alu_request, alu_operandA/B, alu_opcode, rsp_valid, rsp_result, rsp_timeout, rsp_last, done, txn_count.
  - cmd_ready=1.
  - FIFO emptied; FSM=IDLE.
- Reset mid-operation: any in-flight command, buffered command or pending response is discarded. alu_request=0 on the first cycle after the reset edge. A late alu_valid is ignored.
- cmd_ready = !fifo_full && state!=DONE.
  - Push and pop in the same edge are allowed.
  - A pop does not raise cmd_ready combinationally.
- FSM states: IDLE, ISSUE, RESP, DONE.
- IDLE:
  - If FIFO non-empty at an edge: pop head into issue registers (alu_operandA/B, alu_opcode, last flag). Set alu_request=1, clear timeout counter, go ISSUE.
  - Latency: a command pushed into an empty FIFO at edge E is popped at E+1, so alu_request is high after E+1.
- ISSUE:
  - alu_request and alu_operand/opcode are held stable.
  - Counter increments each cycle.
  - If alu_valid=1 at an edge: capture alu_result into rsp_result, rsp_timeout=0, alu_request=0, rsp_valid=1, go RESP.
  - Else if counter==TIMEOUT-1: rsp_result=0, rsp_timeout=1, alu_request=0, rsp_valid=1, go RESP. alu_request is therefore high for exactly TIMEOUT cycles.
  - If alu_valid and timeout coincide, alu_valid wins.
- alu_valid outside ISSUE is ignored.
- RESP:
  - rsp_valid, rsp_result, rsp_timeout and rsp_last are held stable until rsp_ready.
  - At the handshake edge: rsp_valid=0, txn_count++ (saturating).
  - Then go DONE if last, else IDLE.
  - No new alu_request while in RESP. Minimum gap between requests is 2 cycles (RESP, IDLE).
- DONE: done=1, cmd_ready=0, FIFO contents frozen. Left only by reset.
- Responses are strictly in command order; one transaction outstanding maximum.

Test Plan:
- Single add: push a=5, b=7, op=0, last=1; ALU model raises alu_valid 3 cycles after request with result 12 -> alu_request high exactly 3 cycles, operands stable, rsp_result=12, rsp_timeout=0, rsp_last=1; after the rsp handshake done=1, txn_count=1, cmd_ready=0.
- FIFO fill: ALU silent, TIMEOUT=255, push continuously -> exactly 5 commands accepted (1 in ISSUE + 4 buffered), then cmd_ready=0. Enable ALU (result = a+b) -> 5 responses in push order; cmd_ready returns 1 the cycle after the first FIFO pop.
- Timeout: ALU never asserts valid -> alu_request high exactly 255 cycles, rsp_result=0, rsp_timeout=1; the next queued command issues 2 cycles after the rsp handshake.
- Valid/timeout tie: alu_valid pulsed on the 255th request cycle with result 0xDEADBEEF -> rsp_result=0xDEADBEEF, rsp_timeout=0.
- Backpressure: hold rsp_ready=0 for 10 cycles with 2 commands queued -> rsp_valid/rsp_result stable for all 10 cycles, alu_request stays 0, txn_count unchanged until the handshake.
- Reset mid-ISSUE: drive reset=0 for one edge while alu_request=1 and 3 commands are queued -> next cycle alu_request=0, rsp_valid=0, cmd_ready=1, done=0, txn_count=0; a subsequent alu_valid pulse produces no response.
